// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite subordinate register bank: G_NB_REGS data-wide registers, each read/write or
// read-only (fed from reg_in), with byte strobes and SLVERR on bad index or read-only write.
module axi4_lite_slave_regfile #(
  parameter int                   G_AXI4_LITE_ADDR_WIDTH = 32,
  parameter int                   G_AXI4_LITE_DATA_WIDTH = 32,
  parameter int                   G_NB_REGS              = 16,
  parameter logic [G_NB_REGS-1:0] G_RO_MASK              = '0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          awvalid,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]             awaddr,
  input  logic [2:0]                                    awprot,
  output logic                                          awready,
  input  logic                                          wvalid,
  input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]             wdata,
  input  logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]           wstrb,
  output logic                                          wready,
  output logic                                          bvalid,
  output logic [1:0]                                    bresp,
  input  logic                                          bready,
  input  logic                                          arvalid,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]             araddr,
  input  logic [2:0]                                    arprot,
  output logic                                          arready,
  output logic                                          rvalid,
  output logic [G_AXI4_LITE_DATA_WIDTH-1:0]             rdata,
  output logic [1:0]                                    rresp,
  input  logic                                          rready,
  output logic [G_NB_REGS*G_AXI4_LITE_DATA_WIDTH-1:0]   reg_out,
  input  logic [G_NB_REGS*G_AXI4_LITE_DATA_WIDTH-1:0]   reg_in,
  output logic [G_NB_REGS-1:0]                          wr_pulse
);
  localparam int AW    = G_AXI4_LITE_ADDR_WIDTH;
  localparam int DW    = G_AXI4_LITE_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int ALIGN = $clog2(SW);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  wr_state_e               wr_state_q, wr_state_d;
  rd_state_e               rd_state_q, rd_state_d;
  logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AW-1:0]           awaddr_q, awaddr_d;
  logic [DW-1:0]           wdata_q, wdata_d;
  logic [SW-1:0]           wstrb_q, wstrb_d;
  logic                    awready_q, awready_d, wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [G_NB_REGS-1:0]    wr_pulse_q, wr_pulse_d;
  logic [DW-1:0]           regs_q [G_NB_REGS];
  logic [DW-1:0]           regs_d [G_NB_REGS];
  logic                    arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0]           rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [AW-1:0]           aw_idx, ar_idx;
  logic                    unused_ok;

  // Word index: sub-word address bits are ignored, upper bits still take part in the range check.
  assign aw_idx    = awaddr_q >> ALIGN;
  assign ar_idx    = araddr >> ALIGN;
  assign unused_ok = ^{awprot, arprot, reg_in};

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (awvalid && awready_q) begin
          awaddr_d  = awaddr;
          aw_held_d = 1'b1;
        end
        if (wvalid && wready_q) begin
          wdata_d  = wdata;
          wstrb_d  = wstrb;
          w_held_d = 1'b1;
        end
        if (aw_held_q && w_held_q) begin
          wr_state_d = WR_RESP;
          bvalid_d   = 1'b1;
          bresp_d    = RESP_SLVERR;
          for (int i = 0; i < G_NB_REGS; i++) begin
            if (aw_idx == AW'(i) && !G_RO_MASK[i]) begin
              bresp_d       = RESP_OKAY;
              wr_pulse_d[i] = 1'b1;
              for (int k = 0; k < SW; k++) begin
                if (wstrb_q[k]) regs_d[i][8*k +: 8] = wdata_q[8*k +: 8];
              end
            end
          end
        end
      end
      WR_RESP: begin
        if (bready) begin
          wr_state_d = WR_IDLE;
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
    endcase
    awready_d = (wr_state_d == WR_IDLE) && !aw_held_d;
    wready_d  = (wr_state_d == WR_IDLE) && !w_held_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      // NOTE: the register bank is reset too, software relies on zeroed control registers.
      for (int i = 0; i < G_NB_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  // Reads sample regs_q, so a write committing on the same edge returns the old value.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (arvalid && arready_q) begin
          rd_state_d = RD_DATA;
          rvalid_d   = 1'b1;
          rdata_d    = '0;
          rresp_d    = RESP_SLVERR;
          for (int i = 0; i < G_NB_REGS; i++) begin
            if (ar_idx == AW'(i)) begin
              rresp_d = RESP_OKAY;
              rdata_d = G_RO_MASK[i] ? reg_in[i*DW +: DW] : regs_q[i];
            end
          end
        end
      end
      RD_DATA: begin
        if (rready) begin
          rd_state_d = RD_IDLE;
          rvalid_d   = 1'b0;
        end
      end
    endcase
    arready_d = (rd_state_d == RD_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  for (genvar g = 0; g < G_NB_REGS; g++) begin : g_reg_out
    assign reg_out[g*DW +: DW] = G_RO_MASK[g] ? '0 : regs_q[g];
  end

  assign awready  = awready_q;
  assign wready   = wready_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign wr_pulse = wr_pulse_q;
  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
endmodule
